// File: rtl/usb_fs_tx_pkt_fmt.sv
// USB full-speed transmit packet formatter: PID, pulled payload and CRC16 out as a
// valid/ready byte stream, with packet completion reported after the serializer's EOP.
module usb_fs_tx_pkt_fmt #(
    parameter int MAX_PKT_BYTES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_pkt_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_data_avail,
    output logic       tx_data_get,
    input  logic [7:0] tx_data,
    output logic       tx_pkt_end,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_last,
    input  logic       eop_done,
    output logic       busy
);

    localparam int CW = $clog2(MAX_PKT_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_WAIT_EOP
    } state_t;

    state_t        state_q, state_d;
    logic          is_data_q, is_data_d;
    logic [15:0]   crc_q, crc_d;
    logic [CW-1:0] byte_count_q, byte_count_d;
    logic [1:0]    cooldown_q, cooldown_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_last_q, byte_last_d;
    logic          tx_pkt_end_q, tx_pkt_end_d;
    logic          handshake;

    // CRC-16/USB, reflected polynomial, one full byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign handshake = byte_valid_q && byte_ready;

    always_comb begin
        state_d      = state_q;
        is_data_d    = is_data_q;
        crc_d        = crc_q;
        byte_count_d = byte_count_q;
        cooldown_d   = (cooldown_q != 2'd0) ? cooldown_q - 2'd1 : 2'd0;
        byte_valid_d = byte_valid_q;
        byte_data_d  = byte_data_q;
        byte_last_d  = byte_last_q;
        tx_pkt_end_d = 1'b0;
        tx_data_get  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_pkt_start) begin
                    is_data_d    = (tx_pid[1:0] == 2'b11);
                    crc_d        = 16'hFFFF;
                    byte_count_d = '0;
                    byte_valid_d = 1'b1;
                    byte_data_d  = {~tx_pid, tx_pid};
                    byte_last_d  = (tx_pid[1:0] != 2'b11);
                    state_d      = S_PID;
                end
            end
            S_PID: begin
                if (handshake) begin
                    byte_valid_d = 1'b0;
                    state_d      = is_data_q ? S_DATA : S_WAIT_EOP;
                end
            end
            S_DATA: begin
                if (byte_valid_q) begin
                    if (handshake) byte_valid_d = 1'b0;
                end else if (cooldown_q == 2'd0) begin
                    // The engine's registered path needs two cycles after a get to settle.
                    if (tx_data_avail && (byte_count_q < CW'(MAX_PKT_BYTES))) begin
                        tx_data_get  = 1'b1;
                        byte_valid_d = 1'b1;
                        byte_data_d  = tx_data;
                        byte_last_d  = 1'b0;
                        crc_d        = crc16_byte(crc_q, tx_data);
                        byte_count_d = byte_count_q + CW'(1);
                        cooldown_d   = 2'd2;
                    end else begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = ~crc_q[7:0];
                        byte_last_d  = 1'b0;
                        state_d      = S_CRC_LO;
                    end
                end
            end
            S_CRC_LO: begin
                if (handshake) begin
                    byte_data_d = ~crc_q[15:8];
                    byte_last_d = 1'b1;
                    state_d     = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (handshake) begin
                    byte_valid_d = 1'b0;
                    state_d      = S_WAIT_EOP;
                end
            end
            S_WAIT_EOP: begin
                if (eop_done) begin
                    tx_pkt_end_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            is_data_q    <= 1'b0;
            crc_q        <= 16'hFFFF;
            byte_count_q <= '0;
            cooldown_q   <= 2'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_last_q  <= 1'b0;
            tx_pkt_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_data_q    <= is_data_d;
            crc_q        <= crc_d;
            byte_count_q <= byte_count_d;
            cooldown_q   <= cooldown_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_last_q  <= byte_last_d;
            tx_pkt_end_q <= tx_pkt_end_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_last  = byte_last_q;
    assign tx_pkt_end = tx_pkt_end_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_fs_tx_pkt_fmt.sv
// Bench for usb_fs_tx_pkt_fmt: engine and serializer models, expected byte stream
// built from the packet rules with a bit-serial CRC, checked on every handshake.
module tb_usb_fs_tx_pkt_fmt;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_pkt_start;
    logic [3:0] tx_pid;
    logic       tx_data_avail;
    logic       tx_data_get;
    logic [7:0] tx_data;
    logic       tx_pkt_end;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       eop_done;
    logic       busy;

    always #5 clk = ~clk;

    usb_fs_tx_pkt_fmt #(.MAX_PKT_BYTES(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tx_pkt_start(tx_pkt_start),
        .tx_pid(tx_pid),
        .tx_data_avail(tx_data_avail),
        .tx_data_get(tx_data_get),
        .tx_data(tx_data),
        .tx_pkt_end(tx_pkt_end),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_data(byte_data),
        .byte_last(byte_last),
        .eop_done(eop_done),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pl[$];
    int  idx = 0;
    int  stage = 0;
    bit  get_pending = 1'b0;
    int  ready_pct = 100;
    bit  mon_en = 1'b0;
    int  get_count = 0;
    int  end_count = 0;
    int  since_get = 100;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit-serial LFSR over the first n payload bytes, LSB first; returns the sent value.
    function automatic logic [15:0] model_crc(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pl[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic build_expected(input logic [3:0] pid, input int n);
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back({(pid[1:0] != 2'b11), ~pid, pid});
        if (pid[1:0] == 2'b11) begin
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pl[i]});
            c = model_crc(n);
            exp_q.push_back({1'b0, c[7:0]});
            exp_q.push_back({1'b1, c[15:8]});
        end
    endtask

    // Engine and serializer drivers: a get is followed by one cycle of unsettled data.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (get_pending) begin
                get_pending = 1'b0;
                idx++;
                stage = 1;
            end
            if (stage == 1) begin
                tx_data       = 8'($urandom);
                tx_data_avail = 1'($urandom);
                stage = 0;
            end else begin
                tx_data_avail = (idx < pl.size());
                tx_data       = (idx < pl.size()) ? pl[idx] : 8'h00;
            end
            byte_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    always @(negedge clk) begin
        if (tx_data_get) get_pending = 1'b1;
        if (mon_en) begin
            since_get++;
            if (prev_stall) begin
                check("stall_valid", {31'd0, byte_valid}, 32'd1);
                check("stall_data", {24'd0, byte_data}, {24'd0, prev_data});
                check("stall_last", {31'd0, byte_last}, {31'd0, prev_last});
            end
            if (tx_data_get) begin
                check("get_while_valid", {31'd0, byte_valid}, 32'd0);
                tests++;
                if (since_get < 3) begin
                    fails++;
                    $display("FAIL get_spacing: got %0d cycles required >=3", since_get);
                end
                since_get = 0;
                get_count++;
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, byte_last, byte_data}, 32'h1FF);
                end else begin
                    check("byte_data", {24'd0, byte_data}, {24'd0, exp_q[0][7:0]});
                    check("byte_last", {31'd0, byte_last}, {31'd0, exp_q[0][8]});
                    void'(exp_q.pop_front());
                end
            end
            if (tx_pkt_end) end_count++;
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            prev_last  = byte_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_pkt(input logic [3:0] pid);
        @(posedge clk);
        #1;
        tx_pid       = pid;
        tx_pkt_start = 1'b1;
        @(posedge clk);
        #1;
        tx_pkt_start = 1'b0;
        tx_pid       = 4'($urandom);
    endtask

    task automatic run_pkt(input logic [3:0] pid, input int pct, input bit inject,
                           input logic [7:0] first_lit);
        int n_exp;
        int n;
        n_exp = (pid[1:0] == 2'b11) ? ((pl.size() > 64) ? 64 : pl.size()) : 0;
        build_expected(pid, n_exp);
        ready_pct   = pct;
        get_pending = 1'b0;
        idx         = 0;
        get_count   = 0;
        end_count   = 0;
        since_get   = 100;
        start_pkt(pid);
        @(negedge clk);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_valid", {31'd0, byte_valid}, 32'd1);
        check("pid_byte", {24'd0, byte_data}, {24'd0, ~pid, pid});
        check("pid_byte_lit", {24'd0, byte_data}, {24'd0, first_lit});
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (inject && n == 6) begin
                tx_pkt_start = 1'b1;
                tx_pid       = 4'b0010;
            end
            if (inject && n == 7) tx_pkt_start = 1'b0;
        end
        check("bytes_remaining", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat ($urandom_range(3)) @(negedge clk);
        check("busy_before_eop", {31'd0, busy}, 32'd1);
        check("no_early_end", {31'd0, tx_pkt_end}, 32'd0);
        @(posedge clk);
        #1 eop_done = 1'b1;
        @(posedge clk);
        #1 eop_done = 1'b0;
        @(negedge clk);
        check("pkt_end", {31'd0, tx_pkt_end}, 32'd1);
        check("busy_at_end", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("pkt_end_pulse", {31'd0, tx_pkt_end}, 32'd0);
        check("get_count", get_count, n_exp);
        check("end_count", end_count, 32'd1);
    endtask

    task automatic load_digits();
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, byte_valid}, 32'd0);
        check({tag, "_data"}, {24'd0, byte_data}, 32'd0);
        check({tag, "_last"}, {31'd0, byte_last}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_get"}, {31'd0, tx_data_get}, 32'd0);
        check({tag, "_end"}, {31'd0, tx_pkt_end}, 32'd0);
    endtask

    initial begin
        logic [3:0] pids[5];
        int n;
        pids = '{4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110};
        reset_n       = 1'b0;
        tx_pkt_start  = 1'b0;
        tx_pid        = 4'h0;
        tx_data_avail = 1'b0;
        tx_data       = 8'h00;
        byte_ready    = 1'b1;
        eop_done      = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        load_digits();
        check("model_crc_digits", {16'd0, model_crc(9)}, 32'h0000B4C8);
        check("model_crc_empty", {16'd0, model_crc(0)}, 32'h00000000);

        pl.delete();
        pl.push_back(8'hAA);
        pl.push_back(8'h55);
        run_pkt(4'b0010, 100, 1'b0, 8'hD2);

        load_digits();
        run_pkt(4'b1011, 100, 1'b0, 8'h4B);

        pl.delete();
        run_pkt(4'b0011, 100, 1'b0, 8'hC3);

        load_digits();
        run_pkt(4'b1011, 30, 1'b1, 8'h4B);

        pl.delete();
        for (int i = 0; i < 70; i++) pl.push_back(8'($urandom));
        run_pkt(4'b0011, 100, 1'b0, 8'hC3);

        pl.delete();
        for (int i = 0; i < 40; i++) pl.push_back(8'($urandom));
        build_expected(4'b1011, 40);
        ready_pct   = 100;
        get_pending = 1'b0;
        idx         = 0;
        get_count   = 0;
        since_get   = 100;
        start_pkt(4'b1011);
        n = 0;
        while (get_count < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_data", {31'd0, (get_count >= 3)}, 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        mon_en = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("held_reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        pl.delete();
        run_pkt(4'b1010, 100, 1'b0, 8'h5A);

        for (int k = 0; k < 8; k++) begin
            logic [3:0] p;
            p = pids[$urandom_range(4)];
            pl.delete();
            for (int i = 0; i < int'($urandom_range(20)); i++) pl.push_back(8'($urandom));
            run_pkt(p, int'($urandom_range(20, 100)), 1'b1, {~p, p});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
